// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings and counter sizing.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bit counter width: enough to reach WIDTH-1 without wrapping, never below one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_sub_full_sub.sv
// One-bit full subtractor: diff = a - b - bi, borrow out of this bit position.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic diff,
    output logic borrow
);

    // Pure combinational difference and borrow.
    always_comb begin
        diff   = a ^ b ^ bi;
        borrow = (~a & b) | (~(a ^ b) & bi);
    end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    // Upper WIDTH-1 result bits collected so far; the newest bit joins at the top.
    logic [WIDTH-2:0] d_sh_q, d_sh_d;
    logic             brw_q, brw_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic bit_d;
    logic bit_bn;

    // Single per-bit datapath cell fed from the operand shift registers.
    full_sub u_full_sub (
        .a      (a_sh_q[0]),
        .b      (b_sh_q[0]),
        .bi     (brw_q),
        .diff   (bit_d),
        .borrow (bit_bn)
    );

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            d_sh_q  <= '0;
            brw_q   <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            d_sh_q  <= d_sh_d;
            brw_q   <= brw_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Next-state and datapath sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        d_sh_d  = d_sh_q;
        brw_d   = brw_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    brw_d   = bin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                d_sh_d = (WIDTH-1)'({bit_d, d_sh_q} >> 1);
                brw_d  = bit_bn;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_d  = {bit_d, d_sh_q};
                    bout_d  = bit_bn;
`ifdef SERIAL_SUB_OVF_EN
                    // Borrow into the MSB differs from borrow out of it on signed overflow.
                    ovf_d   = brw_q ^ bit_bn;
`endif
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub (WIDTH=8); ovf checked when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int n_pass;
    int n_total;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic       vbin;
        logic [7:0] ediff;
        logic       ebout;
        logic       eovf;
    } vec_t;

    vec_t vecs [8];

    serial_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Wait (bounded) until the DUT is idle, sampling at the falling edge.
    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 30) begin
            @(negedge clk);
            k++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Issue one operation; lat = edges from the accepting edge until done is seen, -1 on timeout.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin,
                          output int lat);
        wait_idle();
        a = ta; b = tb_v; bin = tbin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int e0, e1, e2, nd;

        n_pass = 0; n_total = 0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h05, 8'h03, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[2] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[7] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

        // Reset state.
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        #10 rst_n = 1'b1;

        // Table-driven vectors.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vbin, lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd8);
            chk($sformatf("v%0d_diff", i), 32'(diff), 32'(vecs[i].ediff));
            chk($sformatf("v%0d_bout", i), 32'(bout), 32'(vecs[i].ebout));
`ifdef SERIAL_SUB_OVF_EN
            chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].eovf));
`endif
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
            chk($sformatf("v%0d_busy_clear", i), 32'(busy), 32'd0);
        end

        // start pulsed during RUN is ignored.
        wait_idle();
        a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        a = 8'hFF; b = 8'h00; bin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ign_diff_stable", 32'(diff), 32'h00);
        lat = -1;
        for (int k = 5; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        chk("ign_latency", 32'(lat), 32'd8);
        chk("ign_diff", 32'(diff), 32'h02);
        repeat (12) @(posedge clk);
        #1;
        chk("ign_no_second_done", 32'(busy), 32'd0);

        // start held high: done every WIDTH+2 edges.
        wait_idle();
        a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
        e0 = -1; e1 = -1; e2 = -1; nd = 0;
        for (int k = 0; k < 35; k++) begin
            @(posedge clk); #1;
            if (done) begin
                if (nd == 0) e0 = k;
                else if (nd == 1) e1 = k;
                else if (nd == 2) e2 = k;
                nd++;
            end
        end
        start = 1'b0;
        chk("held_first_done", 32'(e0), 32'd8);
        chk("held_period1", 32'(e1 - e0), 32'd10);
        chk("held_period2", 32'(e2 - e1), 32'd10);

        // Async reset mid-run, then a clean restart.
        run_op(8'h05, 8'h03, 1'b0, lat);
        chk("pre_rst_diff", 32'(diff), 32'h02);
        wait_idle();
        a = 8'hFF; b = 8'h0F; bin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_diff", 32'(diff), 32'd0);
        chk("arst_bout", 32'(bout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'hA5, 8'h5A, 1'b0, lat);
        chk("restart_latency", 32'(lat), 32'd8);
        chk("restart_diff", 32'(diff), 32'h4B);
        chk("restart_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("restart_ovf", 32'(ovf), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
